frv_mem_arbiter: RTL and testbench



---
 rtl/frv_mem_arb_pkg.sv | 9 +
 rtl/frv_mem_arb_srcfifo.sv | 59 +++++
 rtl/frv_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_frv_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_arb_pkg.sv
// Shared types for the frv memory arbiter: response-source encoding.
package frv_mem_arb_pkg;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } mem_src_t;

endpackage

// File: rtl/frv_mem_arb_srcfifo.sv
// In-order FIFO of request sources (imem/dmem) for accepted, unanswered requests.
// Push is ignored when full and pop is ignored when empty; pointers wrap modulo DEPTH.
module frv_mem_arb_srcfifo
  import frv_mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  mem_src_t din,
  output mem_src_t head,
  output logic     full,
  output logic     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  mem_src_t      slots [DEPTH];
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // Pointer, occupancy and storage update; reset discards all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= SRC_IMEM;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_arbiter.sv
// Shares one memory port between the imem and dmem channels of frv_core.
// Optional macro FRV_MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of
// fixed dmem priority.
module frv_mem_arbiter
  import frv_mem_arb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic            g_clk,
  input  logic            reset,
  input  logic            imem_req,
  input  logic            imem_wen,
  input  logic [3:0]      imem_strb,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_gnt,
  output logic            imem_recv,
  input  logic            imem_ack,
  output logic            imem_error,
  output logic [XLEN-1:0] imem_rdata,
  input  logic            dmem_req,
  input  logic            dmem_wen,
  input  logic [3:0]      dmem_strb,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_addr,
  output logic            dmem_gnt,
  output logic            dmem_recv,
  input  logic            dmem_ack,
  output logic            dmem_error,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            mem_req,
  output logic            mem_wen,
  output logic [3:0]      mem_strb,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_recv,
  input  logic            mem_error,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_ack,
  output logic            arb_spurious
);

  mem_src_t sel;
  mem_src_t tie_src;
  mem_src_t head;
  mem_src_t lock_src;
  logic     lock_vld;
  logic     sel_req;
  logic     fifo_full;
  logic     fifo_empty;
  logic     grant;
  logic     resp_vld;
  logic     route_imem;
  logic     route_dmem;

`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
  mem_src_t prio_q;

  // Tie winner for the next arbitration is always the channel just passed over.
  always_ff @(posedge g_clk or posedge reset) begin
    if (reset)      prio_q <= SRC_IMEM;
    else if (grant) prio_q <= (sel == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
  end

  assign tie_src = prio_q;
`else
  assign tie_src = SRC_DMEM;
`endif

  // Channel selection: a pending lock wins, then a lone requester, then the tie rule.
  always_comb begin
    sel = tie_src;
    if (lock_vld)                   sel = lock_src;
    else if (imem_req && !dmem_req) sel = SRC_IMEM;
    else if (dmem_req && !imem_req) sel = SRC_DMEM;
  end

  assign sel_req   = (sel == SRC_DMEM) ? dmem_req : imem_req;
  assign mem_req   = sel_req & ~fifo_full & ~reset;
  assign mem_wen   = (sel == SRC_DMEM) ? dmem_wen   : imem_wen;
  assign mem_strb  = (sel == SRC_DMEM) ? dmem_strb  : imem_strb;
  assign mem_wdata = (sel == SRC_DMEM) ? dmem_wdata : imem_wdata;
  assign mem_addr  = (sel == SRC_DMEM) ? dmem_addr  : imem_addr;
  assign grant     = mem_req & mem_gnt;
  assign imem_gnt  = grant & (sel == SRC_IMEM);
  assign dmem_gnt  = grant & (sel == SRC_DMEM);

  // Hold selection on a channel that is waiting for its grant so the shared
  // request cannot change underneath the memory; a dropped req also releases it.
  always_ff @(posedge g_clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_src <= SRC_IMEM;
    end else begin
      lock_vld <= sel_req & ~grant;
      lock_src <= sel;
    end
  end

  frv_mem_arb_srcfifo #(
    .DEPTH (OUTSTANDING)
  ) u_srcfifo (
    .clk   (g_clk),
    .rst   (reset),
    .push  (grant),
    .pop   (mem_recv & mem_ack),
    .din   (sel),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign resp_vld   = ~fifo_empty & ~reset;
  assign route_imem = resp_vld & (head == SRC_IMEM);
  assign route_dmem = resp_vld & (head == SRC_DMEM);
  assign imem_recv  = route_imem & mem_recv;
  assign dmem_recv  = route_dmem & mem_recv;
  assign imem_error = route_imem & mem_error;
  assign dmem_error = route_dmem & mem_error;
  assign imem_rdata = route_imem ? mem_rdata : '0;
  assign dmem_rdata = route_dmem ? mem_rdata : '0;
  assign mem_ack    = (route_imem & imem_ack) | (route_dmem & dmem_ack);

  // Sticky record of a response arriving with nothing outstanding.
  always_ff @(posedge g_clk or posedge reset) begin
    if (reset)                       arb_spurious <= 1'b0;
    else if (fifo_empty && mem_recv) arb_spurious <= 1'b1;
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed self-checking bench for frv_mem_arbiter.
module tb_frv_mem_arbiter;

  localparam int XLEN = 32;

  logic            g_clk;
  logic            reset;
  logic            imem_req, imem_wen, imem_ack;
  logic [3:0]      imem_strb;
  logic [XLEN-1:0] imem_wdata, imem_addr;
  logic            imem_gnt, imem_recv, imem_error;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req, dmem_wen, dmem_ack;
  logic [3:0]      dmem_strb;
  logic [XLEN-1:0] dmem_wdata, dmem_addr;
  logic            dmem_gnt, dmem_recv, dmem_error;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_req, mem_wen, mem_ack;
  logic [3:0]      mem_strb;
  logic [XLEN-1:0] mem_wdata, mem_addr;
  logic            mem_gnt, mem_recv, mem_error;
  logic [XLEN-1:0] mem_rdata;
  logic            arb_spurious;

  int n_cmp = 0;
  int n_bad = 0;

  frv_mem_arbiter #(.XLEN(XLEN), .OUTSTANDING(2)) dut (
    .g_clk(g_clk), .reset(reset),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_recv(mem_recv), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .arb_spurious(arb_spurious)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  task automatic idle();
    imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_wdata = '0; imem_addr = '0; imem_ack = 0;
    dmem_req = 0; dmem_wen = 0; dmem_strb = 4'h0; dmem_wdata = '0; dmem_addr = '0; dmem_ack = 0;
    mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    imem_req = 1; dmem_req = 1; mem_gnt = 1; mem_recv = 1; imem_ack = 1; dmem_ack = 1;
    #2;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b00) begin n_bad++; $display("FAIL rst_gnt got=%b exp=00", {imem_gnt, dmem_gnt}); end
    n_cmp++; if ({imem_recv, dmem_recv, mem_ack} !== 3'b000) begin n_bad++; $display("FAIL rst_resp got=%b exp=000", {imem_recv, dmem_recv, mem_ack}); end
    step();
    n_cmp++; if (arb_spurious !== 1'b0) begin n_bad++; $display("FAIL rst_spurious got=%b exp=0", arb_spurious); end
    idle();
    reset = 0;
    step();
  endtask

  task automatic test_single_read();
    imem_req = 1; imem_addr = 32'h100; mem_gnt = 1;
    #1;
    n_cmp++; if ({mem_req, imem_gnt, dmem_gnt} !== 3'b110) begin n_bad++; $display("FAIL rd_issue got=%b exp=110", {mem_req, imem_gnt, dmem_gnt}); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_addr got=%h exp=00000100", mem_addr); end
    step();
    idle();
    mem_recv = 1; mem_rdata = 32'hDEADBEEF; imem_ack = 1;
    #1;
    n_cmp++; if ({imem_recv, dmem_recv, mem_ack} !== 3'b101) begin n_bad++; $display("FAIL rd_recv got=%b exp=101", {imem_recv, dmem_recv, mem_ack}); end
    n_cmp++; if (imem_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", imem_rdata); end
    n_cmp++; if (dmem_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_other_rdata got=%h exp=0", dmem_rdata); end
    step();
    idle();
    #1;
    n_cmp++; if (dut.u_srcfifo.empty !== 1'b1) begin n_bad++; $display("FAIL rd_empty got=%b exp=1", dut.u_srcfifo.empty); end
  endtask

  task automatic test_tie();
    logic first_dmem;
`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
    first_dmem = 1'b0;
`else
    first_dmem = 1'b1;
`endif
    imem_req = 1; imem_addr = 32'h200; dmem_req = 1; dmem_addr = 32'h300; mem_gnt = 1;
    #1;
    n_cmp++; if ({imem_gnt, dmem_gnt} !== {~first_dmem, first_dmem}) begin n_bad++; $display("FAIL tie_first got=%b exp=%b", {imem_gnt, dmem_gnt}, {~first_dmem, first_dmem}); end
    n_cmp++; if (mem_addr !== (first_dmem ? 32'h300 : 32'h200)) begin n_bad++; $display("FAIL tie_addr got=%h", mem_addr); end
    step();
    if (first_dmem) dmem_req = 0; else imem_req = 0;
    #1;
    n_cmp++; if ({imem_gnt, dmem_gnt} !== {first_dmem, ~first_dmem}) begin n_bad++; $display("FAIL tie_second got=%b exp=%b", {imem_gnt, dmem_gnt}, {first_dmem, ~first_dmem}); end
    step();
    idle();
    mem_recv = 1; mem_rdata = 32'hA1; imem_ack = 1; dmem_ack = 1;
    #1;
    n_cmp++; if ({imem_recv, dmem_recv} !== {~first_dmem, first_dmem}) begin n_bad++; $display("FAIL tie_resp1 got=%b exp=%b", {imem_recv, dmem_recv}, {~first_dmem, first_dmem}); end
    step();
    mem_rdata = 32'hB2;
    #1;
    n_cmp++; if ({imem_recv, dmem_recv} !== {first_dmem, ~first_dmem}) begin n_bad++; $display("FAIL tie_resp2 got=%b exp=%b", {imem_recv, dmem_recv}, {first_dmem, ~first_dmem}); end
    n_cmp++; if ((first_dmem ? imem_rdata : dmem_rdata) !== 32'hB2) begin n_bad++; $display("FAIL tie_rdata2 got=%h exp=b2", first_dmem ? imem_rdata : dmem_rdata); end
    step();
    idle();
  endtask

  task automatic test_lock();
    imem_req = 1; imem_addr = 32'h500;
    #1;
    n_cmp++; if ({mem_req, imem_gnt} !== 2'b10) begin n_bad++; $display("FAIL lock_c1 got=%b exp=10", {mem_req, imem_gnt}); end
    step();
    dmem_req = 1; dmem_addr = 32'h400;
    #1;
    n_cmp++; if (mem_addr !== 32'h500) begin n_bad++; $display("FAIL lock_addr got=%h exp=00000500", mem_addr); end
    step();
    mem_gnt = 1;
    #1;
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b10) begin n_bad++; $display("FAIL lock_gnt got=%b exp=10", {imem_gnt, dmem_gnt}); end
    step();
    imem_req = 0;
    #1;
    n_cmp++; if ({imem_gnt, dmem_gnt, mem_addr} !== {2'b01, 32'h400}) begin n_bad++; $display("FAIL lock_next got=%b/%h exp=01/00000400", {imem_gnt, dmem_gnt}, mem_addr); end
    step();
    idle();
    mem_recv = 1; imem_ack = 1; dmem_ack = 1; mem_error = 1;
    #1;
    n_cmp++; if ({imem_recv, imem_error, dmem_recv, dmem_error} !== 4'b1100) begin n_bad++; $display("FAIL lock_resp1 got=%b exp=1100", {imem_recv, imem_error, dmem_recv, dmem_error}); end
    step();
    mem_error = 0;
    #1;
    n_cmp++; if ({imem_recv, dmem_recv} !== 2'b01) begin n_bad++; $display("FAIL lock_resp2 got=%b exp=01", {imem_recv, dmem_recv}); end
    step();
    idle();
  endtask

  task automatic test_full();
    dmem_req = 1; dmem_addr = 32'h600; mem_gnt = 1;
    #1;
    n_cmp++; if (dmem_gnt !== 1'b1) begin n_bad++; $display("FAIL full_g1 got=%b exp=1", dmem_gnt); end
    step();
    n_cmp++; if (dmem_gnt !== 1'b1) begin n_bad++; $display("FAIL full_g2 got=%b exp=1", dmem_gnt); end
    step();
    n_cmp++; if ({mem_req, dmem_gnt} !== 2'b00) begin n_bad++; $display("FAIL full_block got=%b exp=00", {mem_req, dmem_gnt}); end
    mem_recv = 1; dmem_ack = 1;
    #1;
    n_cmp++; if ({mem_req, dmem_recv, mem_ack} !== 3'b011) begin n_bad++; $display("FAIL full_nobypass got=%b exp=011", {mem_req, dmem_recv, mem_ack}); end
    step();
    mem_recv = 0;
    #1;
    n_cmp++; if ({mem_req, dmem_gnt} !== 2'b11) begin n_bad++; $display("FAIL full_free got=%b exp=11", {mem_req, dmem_gnt}); end
    step();
    dmem_req = 0; mem_recv = 1;
    step();
    step();
    idle();
    #1;
    n_cmp++; if (dut.u_srcfifo.empty !== 1'b1) begin n_bad++; $display("FAIL full_drain got=%b exp=1", dut.u_srcfifo.empty); end
  endtask

  task automatic test_spurious();
    mem_recv = 1; imem_ack = 1; dmem_ack = 1;
    #1;
    n_cmp++; if ({mem_ack, imem_recv, dmem_recv} !== 3'b000) begin n_bad++; $display("FAIL spur_ack got=%b exp=000", {mem_ack, imem_recv, dmem_recv}); end
    step();
    idle();
    step();
    n_cmp++; if (arb_spurious !== 1'b1) begin n_bad++; $display("FAIL spur_sticky got=%b exp=1", arb_spurious); end
    reset = 1;
    #1;
    n_cmp++; if (arb_spurious !== 1'b0) begin n_bad++; $display("FAIL spur_clear got=%b exp=0", arb_spurious); end
    #1;
    reset = 0;
    step();
  endtask

  task automatic test_reset_mid();
    imem_req = 1; imem_addr = 32'h700; mem_gnt = 1;
    step();
    step();
    reset = 1;
    #1;
    n_cmp++; if ({mem_req, imem_gnt, mem_ack} !== 3'b000) begin n_bad++; $display("FAIL mid_outputs got=%b exp=000", {mem_req, imem_gnt, mem_ack}); end
    n_cmp++; if (dut.u_srcfifo.empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty got=%b exp=1", dut.u_srcfifo.empty); end
    #1;
    reset = 0;
    #1;
    n_cmp++; if ({mem_req, imem_gnt} !== 2'b11) begin n_bad++; $display("FAIL mid_regrant got=%b exp=11", {mem_req, imem_gnt}); end
    step();
    idle();
    mem_recv = 1; mem_rdata = 32'h12345678; imem_ack = 1;
    #1;
    n_cmp++; if ({imem_recv, imem_rdata} !== {1'b1, 32'h12345678}) begin n_bad++; $display("FAIL mid_resp got=%b/%h exp=1/12345678", imem_recv, imem_rdata); end
    step();
    idle();
    step();
    n_cmp++; if (arb_spurious !== 1'b0) begin n_bad++; $display("FAIL mid_spurious got=%b exp=0", arb_spurious); end
  endtask

  initial begin
    reset = 1;
    idle();
    #1;
    test_reset();
    test_single_read();
    test_tie();
    test_lock();
    test_full();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
